// File: rtl/apb_arbiter_if.sv
// One APB port: request side driven by a master, response side driven by a slave.
interface apb_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_WIDTH-1:0]     paddr;
    logic [DATA_WIDTH-1:0]     pdata;
    logic [DATA_WIDTH/8-1:0]   pstb;
    logic [DATA_WIDTH-1:0]     prdata;
    logic                      pready;
    logic                      perr;

    modport master (
        output psel, penable, pwrite, paddr, pdata, pstb,
        input  prdata, pready, perr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pdata, pstb,
        output prdata, pready, perr
    );
endinterface

// File: rtl/apb_arbiter.sv
// Two-master round-robin APB arbiter with one transfer in flight and an
// ACCESS-phase watchdog that turns a hung downstream slave into an error response.
module apb_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic          clk,
    input  logic          rts,
    apb_arbiter_if.slave  m0,
    apb_arbiter_if.slave  m1,
    apb_arbiter_if.master s,
    output logic          grant
);
    localparam int STB_WIDTH = DATA_WIDTH / 8;
    localparam int WD_WIDTH  = $clog2(TIMEOUT + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(TIMEOUT - 1);
    localparam logic [WD_WIDTH-1:0] WD_ONE   = WD_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic                    grant_r;
    logic                    last_r;
    logic [WD_WIDTH-1:0]     wd_r;

    logic                    s_psel_r;
    logic                    s_penable_r;
    logic                    s_pwrite_r;
    logic [ADDR_WIDTH-1:0]   s_paddr_r;
    logic [DATA_WIDTH-1:0]   s_pdata_r;
    logic [STB_WIDTH-1:0]    s_pstb_r;

    logic [DATA_WIDTH-1:0]   rdata_r;
    logic                    perr_r;
    logic [DATA_WIDTH-1:0]   m0_prdata_r;
    logic [DATA_WIDTH-1:0]   m1_prdata_r;

    logic [1:0]              req_s;
    logic                    win_s;
    logic                    take_s;
    logic                    done_s;
    logic                    drop_s;
    logic                    done0_s;
    logic                    done1_s;
    logic                    gnt_psel_s;
    logic                    gnt_penable_s;
    logic                    timeout_s;

    logic                    sel_pwrite_s;
    logic [ADDR_WIDTH-1:0]   sel_paddr_s;
    logic [DATA_WIDTH-1:0]   sel_pdata_s;
    logic [STB_WIDTH-1:0]    sel_pstb_s;

    assign req_s         = {m1.psel, m0.psel};
    assign gnt_psel_s    = grant_r ? m1.psel : m0.psel;
    assign gnt_penable_s = grant_r ? m1.penable : m0.penable;
    assign timeout_s     = (wd_r >= WD_LIMIT);

    // Next-state and arbitration decision; on a tie the master not served last wins.
    always_comb begin
        state_s = state_r;
        win_s   = 1'b0;
        take_s  = 1'b0;
        done_s  = 1'b0;
        drop_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (req_s == 2'b11) begin
                    win_s   = ~last_r;
                    take_s  = 1'b1;
                    state_s = ST_SETUP;
                end else if (req_s[0]) begin
                    win_s   = 1'b0;
                    take_s  = 1'b1;
                    state_s = ST_SETUP;
                end else if (req_s[1]) begin
                    win_s   = 1'b1;
                    take_s  = 1'b1;
                    state_s = ST_SETUP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (s.pready) begin
                    state_s = ST_RESP;
                end else if (timeout_s) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_ACCESS;
                end
            end
            ST_RESP: begin
                if (gnt_psel_s && gnt_penable_s) begin
                    done_s  = 1'b1;
                    state_s = ST_IDLE;
                end else if (gnt_psel_s) begin
                    state_s = ST_RESP;
                end else begin
                    drop_s  = 1'b1;
                    state_s = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Request fields of the winning master, picked only for the capture in IDLE.
    always_comb begin
        sel_pwrite_s = m0.pwrite;
        sel_paddr_s  = m0.paddr;
        sel_pdata_s  = m0.pdata;
        sel_pstb_s   = m0.pstb;
        if (win_s) begin
            sel_pwrite_s = m1.pwrite;
            sel_paddr_s  = m1.paddr;
            sel_pdata_s  = m1.pdata;
            sel_pstb_s   = m1.pstb;
        end else begin
            sel_pwrite_s = m0.pwrite;
            sel_paddr_s  = m0.paddr;
            sel_pdata_s  = m0.pdata;
            sel_pstb_s   = m0.pstb;
        end
    end

    // State register, ownership tracking and downstream bus controls.
    always_ff @(posedge clk) begin
        if (rts) begin
            state_r     <= ST_IDLE;
            grant_r     <= 1'b0;
            last_r      <= 1'b1;
            s_psel_r    <= 1'b0;
            s_penable_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            s_psel_r    <= (state_s == ST_SETUP) || (state_s == ST_ACCESS);
            s_penable_r <= (state_s == ST_ACCESS);
            if (take_s) begin
                grant_r <= win_s;
            end
            if (done_s || drop_s) begin
                last_r <= grant_r;
            end
        end
    end

    // Request fields are captured once at grant and held for the whole transfer.
    always_ff @(posedge clk) begin
        if (rts) begin
            s_pwrite_r <= 1'b0;
            s_paddr_r  <= {ADDR_WIDTH{1'b0}};
            s_pdata_r  <= {DATA_WIDTH{1'b0}};
            s_pstb_r   <= {STB_WIDTH{1'b0}};
        end else if (take_s) begin
            s_pwrite_r <= sel_pwrite_s;
            s_paddr_r  <= sel_paddr_s;
            s_pdata_r  <= sel_pdata_s;
            s_pstb_r   <= sel_pstb_s;
        end
    end

    // Watchdog and response capture; a real s_pready beats a same-cycle timeout.
    always_ff @(posedge clk) begin
        if (rts) begin
            wd_r    <= {WD_WIDTH{1'b0}};
            rdata_r <= {DATA_WIDTH{1'b0}};
            perr_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_SETUP: begin
                    wd_r <= {WD_WIDTH{1'b0}};
                end
                ST_ACCESS: begin
                    wd_r <= wd_r + WD_ONE;
                    if (s.pready) begin
                        rdata_r <= s_pwrite_r ? {DATA_WIDTH{1'b0}} : s.prdata;
                        perr_r  <= s.perr;
                    end else if (timeout_s) begin
                        rdata_r <= {DATA_WIDTH{1'b0}};
                        perr_r  <= 1'b1;
                    end
                end
                default: begin
                    wd_r <= wd_r;
                end
            endcase
        end
    end

    // Per-master read data holds until that master's next completion.
    always_ff @(posedge clk) begin
        if (rts) begin
            m0_prdata_r <= {DATA_WIDTH{1'b0}};
            m1_prdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            if (done0_s) begin
                m0_prdata_r <= rdata_r;
            end
            if (done1_s) begin
                m1_prdata_r <= rdata_r;
            end
        end
    end

    // Completion must land in the cycle the master is waiting in ACCESS, so
    // pready is qualified by the master's own live psel/penable.
    assign done0_s   = done_s & ~grant_r;
    assign done1_s   = done_s & grant_r;

    assign m0.pready = done0_s;
    assign m0.perr   = done0_s & perr_r;
    assign m0.prdata = done0_s ? rdata_r : m0_prdata_r;
    assign m1.pready = done1_s;
    assign m1.perr   = done1_s & perr_r;
    assign m1.prdata = done1_s ? rdata_r : m1_prdata_r;

    assign s.psel    = s_psel_r;
    assign s.penable = s_penable_r;
    assign s.pwrite  = s_pwrite_r;
    assign s.paddr   = s_paddr_r;
    assign s.pdata   = s_pdata_r;
    assign s.pstb    = s_pstb_r;

    assign grant     = grant_r;
endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares one downstream APB slave port (memory/peripheral bus) between two APB masters: m0 (CPU core) and m1 (debug/DMA master).
- Acts as an APB slave to each master and re-issues the granted transfer downstream as an APB master.
- Round-robin arbitration, one transfer in flight, ACCESS-phase watchdog that converts a hung slave into an error response.

Parameters:
ADDR_WIDTH, 32, address width on all ports
DATA_WIDTH, 32, data width on all ports; DATA_WIDTH/8 strobe bits
TIMEOUT, 255, max ACCESS-phase cycles without s_pready before abort; must be >=1

Ports:
clk  in  1  clock, all logic on rising edge
rts  in  1  reset, synchronous, active-high
mN_psel  in  1  master N select (N=0,1; each mN_* port exists for both)
mN_penable  in  1  master N enable (access phase)
mN_pwrite  in  1  master N write
mN_paddr  in  ADDR_WIDTH  master N address
mN_pdata  in  DATA_WIDTH  master N write data
mN_pstb  in  DATA_WIDTH/8  master N byte strobes
mN_prdata  out  DATA_WIDTH  read data to master N
mN_pready  out  1  transfer-complete to master N
mN_perr  out  1  error to master N, valid with mN_pready
s_psel, s_penable, s_pwrite  out  1  downstream APB controls
s_paddr  out  ADDR_WIDTH  downstream address
s_pdata  out  DATA_WIDTH  downstream write data
s_pstb  out  DATA_WIDTH/8  downstream strobes
s_prdata  in  DATA_WIDTH  downstream read data
s_pready  in  1  downstream ready
s_perr  in  1  downstream error, sampled with s_pready
grant  out  1  index of the master owning the current/last transfer

Behaviour:
- Reset (rts=1 at clk edge): state IDLE; all s_* outputs 0; mN_pready=0, mN_perr=0, mN_prdata=0; grant=0; last-served=1 (m0 wins first tie); watchdog=0. Reset mid-transfer drops s_psel/s_penable next cycle; no response is issued to either master.
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: request = mN_psel. None -> stay. One -> grant it. Both -> grant the master not equal to last-served. On grant: latch paddr/pdata/pwrite/pstb of the winner, set grant, go SETUP.
- SETUP: s_psel=1, s_penable=0, latched fields driven; watchdog cleared; next cycle ACCESS.
- ACCESS: s_psel=1, s_penable=1; watchdog increments each cycle. If s_pready=1: latch s_prdata (reads only; writes latch 0) and s_perr, go RESP. Else if watchdog reaches TIMEOUT: latch prdata=0, perr=1, go RESP. s_pready has priority over timeout in the same cycle.
- RESP: s_psel=s_penable=0. If granted master has psel=1 and penable=1: mN_pready=1 for exactly that cycle with latched prdata/perr, last-served=grant, go IDLE. If psel=1, penable=0: wait in RESP. If psel=0 (master abandoned): discard result, update last-served, go IDLE, no pready.
- mN_pready/mN_perr are 1 only in the RESP completion cycle, only for the granted master; the non-granted master sees pready=0 (stalls) throughout. mN_prdata holds the latched value until the next completion to that master.
- Fields are captured once in IDLE; changes on mN_* after grant are ignored.
- Minimum latency: request seen cycle 0, SETUP cycle 1, ACCESS cycle 2 (s_pready=1), mN_pready cycle 3. Back-to-back: next grant earliest cycle 4.
- A master holding psel continuously with both requesting alternates strictly m0,m1,m0,...

Test Plan:
- Single read: m0 read 0x100, slave s_pready=1 first ACCESS cycle, s_prdata=0xDEADBEEF -> s_psel cycles 1-2, m0_pready=1 cycle 3 with m0_prdata=0xDEADBEEF, m0_perr=0.
- Contention: m0 and m1 both request from reset, continuously -> grant order 0,1,0,1; each completion 4 cycles apart; m1_pready never 1 while grant=0.
- Wait states and strobes: m1 write 0x200 data 0x12345678 strb 4'b0011, slave pready after 3 ACCESS cycles -> s_pstb=0011, s_pdata stable, m1_pready one cycle, m1_prdata=0.
- Timeout: TIMEOUT=4, slave never ready -> ACCESS for 4 cycles, then m0_pready=1, m0_perr=1, m0_prdata=0; next request served normally.
- Slave error: s_perr=1 with s_pready -> m0_perr=1 with m0_pready.
- Reset mid-ACCESS and abandonment: rts during ACCESS -> s_psel=0 next cycle, no mN_pready; m1 drops psel during ACCESS -> RESP completes without pready, m0 then granted.
